// File: rtl/latency_meter.sv
// Stimulus-to-response latency meter: times each stim toggle against the next
// synchronized resp_async toggle and keeps running min/max/sum and error counters.
module latency_meter #(
    parameter int unsigned TIMEOUT = 1000000,
    parameter int unsigned SUM_W   = 48
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stim,
    input  logic             stim_done,
    input  logic             resp_async,
    output logic [31:0]      sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [31:0]      min_lat,
    output logic [31:0]      max_lat,
    output logic [SUM_W-1:0] sum_lat,
    output logic [31:0]      n_samples,
    output logic [15:0]      timeouts,
    output logic [15:0]      misses,
    output logic [15:0]      spurious,
    output logic [15:0]      drops,
    output logic             finished
);

    typedef enum logic [1:0] {IDLE, WAIT_RESP, FINISHED} state_t;

    localparam logic [31:0] LAT_LIMIT = 32'(TIMEOUT - 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t           r_state;
    logic [31:0]      r_lat_cnt;
    logic             r_finished;
    logic             r_resp_meta, r_resp_s, r_resp_d, r_stim_d;
    logic [31:0]      r_sample_data, r_min_lat, r_max_lat, r_n_samples;
    logic [SUM_W-1:0] r_sum_lat;
    logic             r_sample_valid;
    logic [15:0]      r_timeouts, r_misses, r_spurious, r_drops;

    logic             w_stim_edge, w_resp_edge, w_in_wait;
    logic             w_hit, w_timeout, w_miss, w_spurious, w_drop;
    logic [31:0]      w_result;
    logic [SUM_W:0]   w_sum_ext;

    // Two-flop synchronizer plus edge-detect history; cleared so a high input after reset is one edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_meta <= 1'b0;
            r_resp_s    <= 1'b0;
            r_resp_d    <= 1'b0;
            r_stim_d    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the previous stage's old value.
            r_resp_meta <= resp_async;
            r_resp_s    <= r_resp_meta;
            r_resp_d    <= r_resp_s;
            r_stim_d    <= stim;
        end
    end

    assign w_stim_edge = stim ^ r_stim_d;
    assign w_resp_edge = r_resp_s ^ r_resp_d;
    assign w_in_wait   = (r_state == WAIT_RESP);
    assign w_result    = r_lat_cnt + 32'd1;
    assign w_hit       = w_in_wait & w_resp_edge;
    assign w_timeout   = w_in_wait & ~w_resp_edge & (r_lat_cnt == LAT_LIMIT);
    assign w_miss      = w_in_wait & w_stim_edge & ~w_resp_edge & ~w_timeout;
    assign w_spurious  = (r_state == IDLE) & ~stim_done & w_resp_edge;
    assign w_drop      = w_hit & r_sample_valid & ~sample_ready;
    assign w_sum_ext   = {1'b0, r_sum_lat} + (SUM_W+1)'(w_result);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_lat_cnt  <= '0;
            r_finished <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (stim_done) begin
                        r_state    <= FINISHED;
                        r_finished <= 1'b1;
                    end else if (w_stim_edge) begin
                        r_lat_cnt <= '0;
                        r_state   <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (w_hit || w_timeout) begin
                        if (stim_done) begin
                            r_state    <= FINISHED;
                            r_finished <= 1'b1;
                        end else if (w_stim_edge) begin
                            r_lat_cnt <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_stim_edge) begin
                        r_lat_cnt <= '0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 32'd1;
                    end
                end
                FINISHED: r_state <= FINISHED;
                default:  r_state <= IDLE;
            endcase
        end
    end

    // Results and counters only move in WAIT_RESP/IDLE, so they freeze once FINISHED.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sample_data  <= '0;
            r_sample_valid <= 1'b0;
            r_min_lat      <= 32'hFFFF_FFFF;
            r_max_lat      <= '0;
            r_sum_lat      <= '0;
            r_n_samples    <= '0;
            r_timeouts     <= '0;
            r_misses       <= '0;
            r_spurious     <= '0;
            r_drops        <= '0;
        end else begin
            if (w_hit) begin
                r_sample_data <= w_result;
                if (w_result < r_min_lat) r_min_lat <= w_result;
                if (w_result > r_max_lat) r_max_lat <= w_result;
                r_sum_lat <= w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
                if (r_n_samples != 32'hFFFF_FFFF) r_n_samples <= r_n_samples + 32'd1;
            end
            if (w_hit)             r_sample_valid <= 1'b1;
            else if (sample_ready) r_sample_valid <= 1'b0;
            if (w_drop)     r_drops    <= sat_inc16(r_drops);
            if (w_timeout)  r_timeouts <= sat_inc16(r_timeouts);
            if (w_miss)     r_misses   <= sat_inc16(r_misses);
            if (w_spurious) r_spurious <= sat_inc16(r_spurious);
        end
    end

    assign sample_data  = r_sample_data;
    assign sample_valid = r_sample_valid;
    assign min_lat      = r_min_lat;
    assign max_lat      = r_max_lat;
    assign sum_lat      = r_sum_lat;
    assign n_samples    = r_n_samples;
    assign timeouts     = r_timeouts;
    assign misses       = r_misses;
    assign spurious     = r_spurious;
    assign drops        = r_drops;
    assign finished     = r_finished;

endmodule

// File: tb/tb_latency_meter.sv
// Directed bench for latency_meter: expected samples go into a queue that a
// handshake monitor drains; statistics are checked directly after each scenario.
module tb_latency_meter;

    localparam int SUM_W = 48;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             stim = 1'b0;
    logic             stim_done = 1'b0;
    logic             resp_async = 1'b0;
    logic             sample_ready = 1'b1;
    logic [31:0]      sample_data, min_lat, max_lat, n_samples;
    logic             sample_valid, finished;
    logic [SUM_W-1:0] sum_lat;
    logic [15:0]      timeouts, misses, spurious, drops;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [31:0]      exp_q[$];

    latency_meter #(.TIMEOUT(100), .SUM_W(SUM_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stim         (stim),
        .stim_done    (stim_done),
        .resp_async   (resp_async),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .min_lat      (min_lat),
        .max_lat      (max_lat),
        .sum_lat      (sum_lat),
        .n_samples    (n_samples),
        .timeouts     (timeouts),
        .misses       (misses),
        .spurious     (spurious),
        .drops        (drops),
        .finished     (finished)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted sample must match the oldest expected one.
    always @(negedge clk) begin
        if (reset_n && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_sample: got %0d expected none", sample_data);
            end else begin
                check("sample_data", 64'(sample_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_reset();
        reset_n      = 1'b0;
        stim         = 1'b0;
        resp_async   = 1'b0;
        stim_done    = 1'b0;
        sample_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pin-level measurement: resp toggles d cycles after stim; measured latency is d+2.
    task automatic measure(input int d);
        @(posedge clk);
        #1 stim = ~stim;
        repeat (d) @(posedge clk);
        #1 resp_async = ~resp_async;
        cycles(6);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_sample_data"}, 64'(sample_data), 64'd0);
        check({tag, "_sample_valid"}, 64'(sample_valid), 64'd0);
        check({tag, "_min"}, 64'(min_lat), 64'hFFFF_FFFF);
        check({tag, "_max"}, 64'(max_lat), 64'd0);
        check({tag, "_sum"}, 64'(sum_lat), 64'd0);
        check({tag, "_n"}, 64'(n_samples), 64'd0);
        check({tag, "_err"}, {timeouts, misses, spurious, drops}, 64'd0);
        check({tag, "_finished"}, 64'(finished), 64'd0);
    endtask

    initial begin
        do_reset();
        cycles(2);
        check_cleared("reset");

        // Single 10-cycle pin latency -> 12 with synchronizer delay.
        exp_q.push_back(32'd12);
        measure(10);
        check("single_min", 64'(min_lat), 64'd12);
        check("single_max", 64'(max_lat), 64'd12);
        check("single_sum", 64'(sum_lat), 64'd12);
        check("single_n", 64'(n_samples), 64'd1);
        check("single_valid_low", 64'(sample_valid), 64'd0);

        // Three back-to-back measurements with ready held high.
        do_reset();
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd22);
        exp_q.push_back(32'd11);
        measure(5);
        measure(20);
        measure(9);
        check("stats_min", 64'(min_lat), 64'd7);
        check("stats_max", 64'(max_lat), 64'd22);
        check("stats_sum", 64'(sum_lat), 64'd40);
        check("stats_n", 64'(n_samples), 64'd3);
        check("stats_drops", 64'(drops), 64'd0);

        // Resp edge one cycle after the stim edge reports latency 1.
        do_reset();
        exp_q.push_back(32'd1);
        @(posedge clk);
        #1 resp_async = 1'b1;
        @(posedge clk);
        #1 stim = 1'b1;
        cycles(6);
        check("lat1_n", 64'(n_samples), 64'd1);
        check("lat1_spurious", 64'(spurious), 64'd0);

        // Response in the last allowed cycle wins over the timeout.
        do_reset();
        exp_q.push_back(32'd100);
        measure(98);
        check("edge_timeouts", 64'(timeouts), 64'd0);
        check("edge_max", 64'(max_lat), 64'd100);

        // No response: timeout, then the late edge is spurious.
        do_reset();
        @(posedge clk);
        #1 stim = 1'b1;
        cycles(110);
        check("to_timeouts", 64'(timeouts), 64'd1);
        check("to_valid", 64'(sample_valid), 64'd0);
        resp_async = 1'b1;
        cycles(6);
        check("to_spurious", 64'(spurious), 64'd1);
        check("to_n", 64'(n_samples), 64'd0);
        check("to_valid_after", 64'(sample_valid), 64'd0);

        // Second stim while waiting is a miss; latency is timed from it.
        do_reset();
        exp_q.push_back(32'd12);
        @(posedge clk);
        #1 stim = 1'b1;
        repeat (30) @(posedge clk);
        #1 stim = 1'b0;
        repeat (10) @(posedge clk);
        #1 resp_async = 1'b1;
        cycles(6);
        check("miss_misses", 64'(misses), 64'd1);
        check("miss_n", 64'(n_samples), 64'd1);
        check("miss_timeouts", 64'(timeouts), 64'd0);

        // Overwrites while ready is low count as drops; only the last result is accepted.
        do_reset();
        sample_ready = 1'b0;
        exp_q.push_back(32'd8);
        measure(3);
        measure(4);
        measure(6);
        check("drop_drops", 64'(drops), 64'd2);
        check("drop_valid", 64'(sample_valid), 64'd1);
        check("drop_data", 64'(sample_data), 64'd8);
        @(posedge clk);
        #1 sample_ready = 1'b1;
        @(posedge clk);
        #1 sample_ready = 1'b0;
        cycles(2);
        check("drop_valid_after", 64'(sample_valid), 64'd0);
        check("drop_n", 64'(n_samples), 64'd3);

        // stim_done mid-measurement: finish the measurement, then freeze.
        do_reset();
        exp_q.push_back(32'd12);
        @(posedge clk);
        #1 stim = 1'b1;
        repeat (3) @(posedge clk);
        #1 stim_done = 1'b1;
        repeat (7) @(posedge clk);
        #1 resp_async = 1'b1;
        cycles(6);
        check("fin_finished", 64'(finished), 64'd1);
        check("fin_n", 64'(n_samples), 64'd1);
        check("fin_sum", 64'(sum_lat), 64'd12);
        stim = 1'b0;
        cycles(3);
        resp_async = 1'b0;
        cycles(10);
        check("fin_frozen_n", 64'(n_samples), 64'd1);
        check("fin_frozen_err", {timeouts, misses, spurious, drops}, 64'd0);
        check("fin_frozen_valid", 64'(sample_valid), 64'd0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_cleared("async_rst");
        check("async_rst_min", 64'(min_lat), 64'hFFFF_FFFF);

        // stim_done in IDLE finishes on the next clock.
        do_reset();
        stim_done = 1'b1;
        cycles(1);
        check("idle_done_finished", 64'(finished), 64'd1);
        stim = 1'b1;
        cycles(6);
        check("idle_done_ignored", 64'(n_samples) | 64'(misses), 64'd0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/latency_meter.md
LATENCY_METER -- requirements
Module: latency_meter

Interface
REQ-001 Parameter TIMEOUT, default 1000000, is the number of cycles in WAIT_RESP before a measurement is abandoned; legal range 2..2^32-1.
REQ-002 Parameter SUM_W, default 48, is the width of the latency accumulator.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset; assertion clears state immediately, deassertion is taken synchronously by clk.
REQ-005 stim  in  1  stimulus level from the upstream edge generator, synchronous to clk; every toggle starts a measurement.
REQ-006 stim_done  in  1  upstream generator finished, synchronous, level.
REQ-007 resp_async  in  1  response pin from the board under test, asynchronous to clk.
REQ-008 sample_data  out  32  latency of the last completed measurement in clk cycles.
REQ-009 sample_valid / sample_ready  out / in  1 / 1  valid/ready handshake for sample_data.
REQ-010 min_lat, max_lat  out  32 each  running minimum and maximum latency.
REQ-011 sum_lat  out  SUM_W  running latency sum; n_samples  out  32  completed measurements.
REQ-012 timeouts, misses, spurious, drops  out  16 each  error counters.
REQ-013 finished  out  1  measurement run complete; statistics frozen.

Function
REQ-014 resp_async SHALL pass through a 2-flop synchronizer to give resp_s; no compensation for synchronizer delay is applied.
REQ-015 stim_edge SHALL be stim XOR its registered copy; resp_edge SHALL be resp_s XOR its registered copy; both directions count.
REQ-016 FSM states SHALL be IDLE, WAIT_RESP, FINISHED.
REQ-017 IDLE with stim_edge: lat_cnt <= 0, go to WAIT_RESP; with resp_edge only: spurious++, stay.
REQ-018 WAIT_RESP: lat_cnt increments by 1 per cycle.
REQ-019 WAIT_RESP with resp_edge: result = lat_cnt+1; update sample_data and statistics; go to IDLE.
REQ-020 A stim edge one cycle followed by a resp edge on the next cycle SHALL report latency 1.
REQ-021 WAIT_RESP with stim_edge and no resp_edge: misses++, lat_cnt <= 0, stay in WAIT_RESP.
REQ-022 WAIT_RESP with stim_edge and resp_edge in the same cycle: complete the measurement per REQ-019, then lat_cnt <= 0 and stay in WAIT_RESP.
REQ-023 IDLE with stim_edge and resp_edge in the same cycle: spurious++ and start the measurement per REQ-017.
REQ-024 WAIT_RESP with lat_cnt == TIMEOUT-1 and no resp_edge: timeouts++, no sample, go to IDLE; a resp_edge in that same cycle wins.
REQ-025 Statistics update per result: min_lat = min(min_lat, result), max_lat = max(max_lat, result), sum_lat += result saturating at all-ones, n_samples++ saturating.
REQ-026 All 16-bit error counters SHALL saturate at 16'hFFFF.
REQ-027 sample_valid SHALL assert the cycle after a result and hold until sampled with sample_ready=1.
REQ-028 sample_data SHALL be stable while sample_valid=1 unless overwritten per REQ-029.
REQ-029 A new result while sample_valid=1 and sample_ready=0: sample_data is overwritten, drops++, sample_valid stays 1.
REQ-030 A new result in the same cycle as an accepting handshake: the new result is loaded, sample_valid stays 1, no drop is counted.
REQ-031 stim_done=1 in IDLE: go to FINISHED next cycle.
REQ-032 stim_done=1 in WAIT_RESP: finish the current measurement (response or timeout) first, then go to FINISHED.
REQ-033 FINISHED: finished=1; all edges ignored; statistics and counters frozen; sample handshake still operates; exit only via reset.

Reset
REQ-034 Assertion of reset_n=0 SHALL, without a clock edge, set state=IDLE and clear lat_cnt, sample_data, sample_valid, max_lat, sum_lat, n_samples, all error counters and finished.
REQ-035 Reset SHALL set min_lat to 32'hFFFFFFFF.
REQ-036 Reset SHALL load synchronizer and edge-detect registers with 0, so a high input after reset produces one edge.
REQ-037 Reset mid-measurement SHALL discard the measurement with no counter change.

Verification
REQ-038 Stimulus: TIMEOUT=100, stim toggles, resp_async toggles 10 cycles later. Required: sample_data=12 (10 + 2 sync), min=max=sum=12, n_samples=1.
REQ-039 Stimulus: latencies 5, 20, 9 (pin-level), sample_ready tied 1. Required: min=7, max=22, sum=40, n_samples=3, drops=0.
REQ-040 Stimulus: no response for 100 cycles, then a late resp edge. Required: timeouts=1, spurious=1, n_samples=0, sample_valid stays 0.
REQ-041 Stimulus: two stim toggles 30 cycles apart with no response, then a response. Required: misses=1, latency measured from the second toggle.
REQ-042 Stimulus: three results with sample_ready=0, then ready pulsed. Required: drops=2, sample_data = third result, sample_valid deasserts after the handshake.
REQ-043 Stimulus: stim_done raised mid-measurement, response arrives, reset_n pulsed low mid-cycle. Required: finished=1 after the sample, later edges ignored; reset clears all outputs asynchronously and min_lat=FFFFFFFF.
